i2s_dac_tx: RTL and testbench

Master-mode I2S transmitter for the audio codec DAC path. It runs in the 12.288 MHz audio clock domain driven by the audio PLL output, and generates BCLK and LRCLK by division. It accepts one stereo sample pair per frame through a valid/ready handshake and serialises the pair MSB-first in standard I2S format. The default configuration gives 3.072 MHz BCLK, 64 BCLK per frame and a 48 kHz sample rate.

---
 rtl/i2s_dac_tx.sv | 150 +++++++++++++++
 tb/tb_i2s_dac_tx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// ---------------------------------------------------------------------------
// i2s_dac_tx : master-mode I2S transmitter for the codec DAC path.
//
// Runs in the audio clock domain and derives BCLK/LRCLK by division. One
// stereo pair per frame is accepted into a single-entry holding register and
// is serialised MSB-first, standard I2S (MSB one BCLK after the LRCLK edge),
// in 32-bit slots, 64 BCLK per frame.
//
// Parameters
//   DATA_W    sample width per channel (16..31), MSB-aligned in a 32-bit slot
//   BCLK_DIV  clk cycles per BCLK period (even, >= 2)
//
// Ports
//   clk          audio clock
//   rst          synchronous active-high reset
//   left_in      left sample, two's complement
//   right_in     right sample, two's complement
//   in_valid     sample pair valid
//   in_ready     holding register empty
//   bclk         bit clock to the codec (registered, 50% duty)
//   lrclk        word select, 0 = left, 1 = right
//   dacdat       serial data, changes on the BCLK falling edge
//   frame_start  one-clk pulse when a new pair is loaded into the shifter
//   underrun     one-clk pulse when a frame starts with no new pair pending
// ---------------------------------------------------------------------------
module i2s_dac_tx #(
  parameter int DATA_W   = 24,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              dacdat,
  output logic              frame_start,
  output logic              underrun
);

  localparam int               DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam int               PAD_W    = 32 - DATA_W;

  logic [DIV_W-1:0]  r_div_cnt;
  logic [5:0]        r_bit_cnt;
  logic              r_bclk;
  logic              r_lrclk;
  logic              r_dacdat;
  logic              r_in_ready;
  logic              r_frame_start;
  logic              r_underrun;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_left;
  logic [DATA_W-1:0] r_hold_right;
  // Shifter holds whole 32-bit slots so the zero padding falls out of the
  // slot contents instead of needing a separate compare.
  logic [31:0]       r_sh_left;
  logic [31:0]       r_sh_right;

  logic              w_div_wrap;
  logic [DIV_W-1:0]  w_div_next;
  logic              w_fall;
  logic [5:0]        w_bit_next;
  logic              w_boundary;
  logic [4:0]        w_slot_idx;
  logic              w_sel_bit;
  logic              w_hs;

  assign w_div_wrap = (r_div_cnt == DIV_MAX);
  assign w_div_next = w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
  // A BCLK falling edge is the cycle in which the divider wraps to 0.
  assign w_fall     = w_div_wrap;
  assign w_bit_next = r_bit_cnt + 6'd1;
  assign w_boundary = w_fall && (r_bit_cnt == 6'd63);

  // The bit sent at new position b is slot position (b-1) mod 64, which is
  // exactly the current bit_cnt: bit 5 picks the channel, bits 4:0 the slot
  // position p, and slot bit 31-p (= ~p) is the data bit.
  assign w_slot_idx = ~r_bit_cnt[4:0];
  assign w_sel_bit  = r_bit_cnt[5] ? r_sh_right[w_slot_idx]
                                   : r_sh_left[w_slot_idx];

  // Handshake: a pair transfers on every clk edge where in_valid and
  // in_ready are both high; in_ready depends only on the holding register,
  // never on in_valid, and stays low until a frame boundary drains the hold.
  assign w_hs = in_valid & r_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_bclk        <= 1'b0;
      r_lrclk       <= 1'b0;
      r_dacdat      <= 1'b0;
      r_in_ready    <= 1'b1;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_hold_full   <= 1'b0;
      r_hold_left   <= '0;
      r_hold_right  <= '0;
      r_sh_left     <= '0;
      r_sh_right    <= '0;
    end else begin
      r_div_cnt     <= w_div_next;
      r_bclk        <= (w_div_next >= DIV_HALF);
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;

      if (w_fall) begin
        r_bit_cnt <= w_bit_next;
        r_lrclk   <= w_bit_next[5];
        // At the boundary this reads right-slot bit 0, which is always pad,
        // so the concurrent shifter reload cannot disturb it.
        r_dacdat  <= w_sel_bit;
      end

      if (w_boundary && r_hold_full) begin
        r_sh_left     <= {r_hold_left,  {PAD_W{1'b0}}};
        r_sh_right    <= {r_hold_right, {PAD_W{1'b0}}};
        r_hold_full   <= 1'b0;
        r_in_ready    <= 1'b1;
        r_frame_start <= 1'b1;
      end else begin
        // No pending pair: the shifter keeps the last pair (repeat). A pair
        // arriving in this very cycle only fills the hold for next frame.
        if (w_boundary) begin
          r_underrun <= 1'b1;
        end
        if (w_hs) begin
          r_hold_left  <= left_in;
          r_hold_right <= right_in;
          r_hold_full  <= 1'b1;
          r_in_ready   <= 1'b0;
        end
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign bclk        = r_bclk;
  assign lrclk       = r_lrclk;
  assign dacdat      = r_dacdat;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_dac_tx : self-checking bench for i2s_dac_tx.
// Two instances: default (24-bit, /4) and narrow (16-bit, /8). The default
// instance is checked every cycle against a frame-level reference model and
// an independent I2S receiver that rebuilds slot words from bclk/lrclk/dacdat.
// ---------------------------------------------------------------------------
module tb_i2s_dac_tx;

  localparam int DW     = 24;
  localparam int DIV    = 4;
  localparam int FRAME  = 64 * DIV;
  localparam int DW2    = 16;
  localparam int DIV2   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tb_cyc = 0;
  always @(posedge clk) tb_cyc <= rst ? 0 : tb_cyc + 1;

  // ---------------- DUT 1 (defaults) ----------------
  logic [DW-1:0] left_in  = '0;
  logic [DW-1:0] right_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, bclk, lrclk, dacdat, frame_start, underrun;

  i2s_dac_tx #(.DATA_W(DW), .BCLK_DIV(DIV)) u_dut (
    .clk(clk), .rst(rst),
    .left_in(left_in), .right_in(right_in), .in_valid(in_valid),
    .in_ready(in_ready), .bclk(bclk), .lrclk(lrclk), .dacdat(dacdat),
    .frame_start(frame_start), .underrun(underrun)
  );

  // ---------------- DUT 2 (16-bit, /8) ----------------
  logic [DW2-1:0] left2  = '0;
  logic [DW2-1:0] right2 = '0;
  logic           in_valid2 = 1'b0;
  logic           in_ready2, bclk2, lrclk2, dacdat2, frame_start2, underrun2;

  i2s_dac_tx #(.DATA_W(DW2), .BCLK_DIV(DIV2)) u_dut2 (
    .clk(clk), .rst(rst),
    .left_in(left2), .right_in(right2), .in_valid(in_valid2),
    .in_ready(in_ready2), .bclk(bclk2), .lrclk(lrclk2), .dacdat(dacdat2),
    .frame_start(frame_start2), .underrun(underrun2)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, tb_cyc);
    end
  endtask

  function automatic logic [31:0] slot24(input logic [DW-1:0] s);
    return 32'(s) << (32 - DW);
  endfunction

  // ---------------- reference model + scoreboard ----------------
  bit            chk_en = 1'b0;
  bit            m_hold_full = 1'b0;
  logic [DW-1:0] m_hold_l = '0, m_hold_r = '0, m_cur_l = '0, m_cur_r = '0;
  bit            m_fs = 1'b0, m_ur = 1'b0;
  int            hs_cnt = 0;
  int            ur_cnt = 0;
  int            ones_cnt = 0;
  logic [31:0]   exp_q[$];

  bit            rx_pb = 1'b0, rx_plr = 1'b0;
  logic [31:0]   rx_sr = '0;
  logic          prev_dacdat = 1'b0;

  bit            rx2_pb = 1'b0, rx2_plr = 1'b0;
  logic [31:0]   rx2_sr = '0;
  logic [31:0]   rx2_q[$];
  int            fs2_cyc = -1;

  initial begin
    logic [31:0] w;
    logic [31:0] e;
    bit          hs;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check_eq("bclk", 32'(bclk), 32'((tb_cyc % DIV) >= DIV / 2));
        check_eq("lrclk", 32'(lrclk), 32'(((tb_cyc / DIV) % 64) >= 32));
        check_eq("in_ready", 32'(in_ready), 32'(!m_hold_full));
        check_eq("frame_start", 32'(frame_start), 32'(m_fs));
        check_eq("underrun", 32'(underrun), 32'(m_ur));
        if (tb_cyc % DIV != 0)
          check_eq("dacdat_stable", 32'(dacdat), 32'(prev_dacdat));
        check_eq("bclk2", 32'(bclk2), 32'((tb_cyc % DIV2) >= DIV2 / 2));
        if (underrun === 1'b1) ur_cnt++;
        if (dacdat === 1'b1) ones_cnt++;
        // I2S receiver: sample on bclk rise; an lrclk change marks the bit
        // just sampled as the last one of the previous channel's slot.
        if (bclk && !rx_pb) begin
          w = {rx_sr[30:0], dacdat};
          if (lrclk != rx_plr) begin
            check_eq("rx_word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check_eq(rx_plr ? "rx_right" : "rx_left", w, e);
            end
          end
          rx_sr  = w;
          rx_plr = lrclk;
        end
        rx_pb = bclk;
        if (bclk2 && !rx2_pb) begin
          w = {rx2_sr[30:0], dacdat2};
          if (lrclk2 != rx2_plr) rx2_q.push_back(w);
          rx2_sr  = w;
          rx2_plr = lrclk2;
        end
        rx2_pb = bclk2;
        if (frame_start2 === 1'b1 && fs2_cyc < 0) fs2_cyc = tb_cyc;
        prev_dacdat = dacdat;
      end
      // advance the model to the next cycle
      if (rst) begin
        m_hold_full = 1'b0;
        m_cur_l = '0; m_cur_r = '0;
        m_fs = 1'b0; m_ur = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);          // first frame after reset is silence
        exp_q.push_back(32'h0);
        rx_pb = 1'b0; rx_plr = 1'b0; rx_sr = '0;
        rx2_pb = 1'b0; rx2_plr = 1'b0; rx2_sr = '0;
        prev_dacdat = 1'b0;
        ones_cnt = 0;
      end else begin
        hs   = in_valid && !m_hold_full;
        m_fs = 1'b0;
        m_ur = 1'b0;
        if ((tb_cyc + 1) % FRAME == 0) begin
          if (m_hold_full) begin
            m_cur_l = m_hold_l; m_cur_r = m_hold_r;
            m_hold_full = 1'b0;
            m_fs = 1'b1;
          end else begin
            m_ur = 1'b1;
          end
          exp_q.push_back(slot24(m_cur_l));
          exp_q.push_back(slot24(m_cur_r));
        end
        if (hs) begin
          m_hold_l = left_in; m_hold_r = right_in;
          m_hold_full = 1'b1;
          hs_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int n);
    int guard = 0;
    while (tb_cyc != n && guard < 20000) begin
      step();
      guard++;
    end
    if (guard >= 20000) check_eq("run_to_timeout", 32'(tb_cyc), 32'(n));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_bclk"},     32'(bclk),        32'd0);
    check_eq({pfx, "_lrclk"},    32'(lrclk),       32'd0);
    check_eq({pfx, "_dacdat"},   32'(dacdat),      32'd0);
    check_eq({pfx, "_in_ready"}, 32'(in_ready),    32'd1);
    check_eq({pfx, "_fs"},       32'(frame_start), 32'd0);
    check_eq({pfx, "_underrun"}, 32'(underrun),    32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] base;
    int seen, k, hs0, ur0, hs1, ur1;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk_en = 1'b1;
    check_reset_outputs("rst");

    // directed pair at cycle 2 into both instances
    run_to(2);
    left_in = 24'hABCDEF; right_in = 24'h123456; in_valid = 1'b1;
    left2 = 16'hBEEF; right2 = 16'h1234; in_valid2 = 1'b1;
    step();
    in_valid = 1'b0; in_valid2 = 1'b0;
    check_eq("ready_fall", 32'(in_ready), 32'd0);
    run_to(255);
    check_eq("fs_not_early", 32'(frame_start), 32'd0);
    run_to(256);
    check_eq("fs_at_256", 32'(frame_start), 32'd1);
    check_eq("lrclk_at_256", 32'(lrclk), 32'd0);
    check_eq("no_underrun_256", 32'(underrun), 32'd0);
    check_eq("pad_at_256", 32'(dacdat), 32'd0);
    run_to(260);
    check_eq("left_msb_260", 32'(dacdat), 32'd1);
    run_to(383);
    check_eq("lrclk_383", 32'(lrclk), 32'd0);
    run_to(384);
    check_eq("lrclk_rise_384", 32'(lrclk), 32'd1);
    run_to(512);
    check_eq("underrun_512", 32'(underrun), 32'd1);

    // continuous valid with incrementing pattern
    run_to(800);
    base = DW'($urandom);
    k = 0;
    left_in = base; right_in = base + DW'(1); in_valid = 1'b1;
    seen = hs_cnt;
    hs0 = 0; ur0 = 0; hs1 = 0; ur1 = 0;
    while (tb_cyc < 2310) begin
      step();
      if (tb_cyc == 1024) begin hs0 = hs_cnt; ur0 = ur_cnt; end
      if (tb_cyc == 2304) begin hs1 = hs_cnt; ur1 = ur_cnt; end
      if (hs_cnt != seen) begin
        seen = hs_cnt;
        k++;
        left_in  = base + DW'(2 * k);
        right_in = base + DW'(2 * k + 1);
      end
    end
    in_valid = 1'b0;
    check_eq("hs_per_5_frames", 32'(hs1 - hs0), 32'd5);
    check_eq("no_underrun_stream", 32'(ur1 - ur0), 32'd0);

    // handshake exactly in a boundary cycle with the hold empty
    run_to(2815);
    left_in = DW'($urandom); right_in = DW'($urandom); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("bnd_underrun", 32'(underrun), 32'd1);
    check_eq("bnd_no_fs", 32'(frame_start), 32'd0);
    check_eq("bnd_ready_low", 32'(in_ready), 32'd0);
    run_to(3072);
    check_eq("bnd_play_next", 32'(frame_start), 32'd1);

    // random traffic with valid held until accepted
    seen = hs_cnt;
    while (tb_cyc < 5000) begin
      step();
      if (hs_cnt != seen) begin
        seen = hs_cnt;
        in_valid = 1'b0;
      end
      if (!in_valid && $urandom_range(0, 149) == 0) begin
        left_in = DW'($urandom); right_in = DW'($urandom); in_valid = 1'b1;
      end
    end
    in_valid = 1'b0;

    // narrow instance: 16 data bits + 16 pad per slot, 512-clk frame
    check_eq("w16_fs_cycle", 32'(fs2_cyc), 32'd512);
    check_eq("w16_rx_count", 32'(rx2_q.size() >= 6), 32'd1);
    if (rx2_q.size() >= 6) begin
      check_eq("w16_silence_l", rx2_q[0], 32'h0);
      check_eq("w16_left",      rx2_q[2], 32'hBEEF0000);
      check_eq("w16_right",     rx2_q[3], 32'h12340000);
      check_eq("w16_repeat_l",  rx2_q[4], 32'hBEEF0000);
      check_eq("w16_repeat_r",  rx2_q[5], 32'h12340000);
    end

    // mid-frame reset at bit_cnt 40 with a pair pending
    run_to(5130);
    left_in = DW'($urandom) | 24'h800000; right_in = DW'($urandom) | 24'h800000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("pending_ready_low", 32'(in_ready), 32'd0);
    run_to(5280);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("mrst");
    run_to(700);
    check_eq("mrst_silence", 32'(ones_cnt), 32'd0);
    check_eq("exp_drain", 32'(exp_q.size()), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
